// File: rtl/boot_rom_pkg.sv
// Shared types for the boot ROM slave: FSM states, response beat, patch entry,
// and the ROM image function that the read path samples.
package boot_rom_pkg;

  localparam int unsigned MAX_READ_LAT = 4;
  localparam int unsigned MAX_DATA_W   = 64;
  localparam int unsigned MAX_PADDR_W  = 32;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  // Response beat; rdata sized for the widest word, narrow builds use the low bits.
  typedef struct packed {
    logic                  opc;
    logic [MAX_DATA_W-1:0] rdata;
  } rsp_t;

  typedef struct packed {
    logic                   valid;
    logic [MAX_PADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0]  data;
  } patch_entry_t;

  // ROM image: low half is 0xC0DE0000 ^ word index, high half its complement.
  function automatic logic [MAX_DATA_W-1:0] rom_word(input logic [31:0] idx);
    logic [31:0] lo;
    lo = 32'hC0DE_0000 ^ idx;
    return {~lo, lo};
  endfunction

endpackage

// File: rtl/boot_rom_rsp_pipe.sv
// Fixed-latency response delay line: STAGES register stages of valid + rsp_t.
// Payload only advances with its valid bit, so the tail holds the last response.
module boot_rom_rsp_pipe
  import boot_rom_pkg::*;
#(
  parameter int unsigned STAGES = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vld_i,
  input  rsp_t rsp_i,
  output logic vld_o,
  output rsp_t rsp_o
);

  if (STAGES == 0) begin : g_bypass
    assign vld_o = vld_i;
    assign rsp_o = rsp_i;
  end else begin : g_pipe
    logic [STAGES-1:0]       vld_q;
    rsp_t [STAGES-1:0]       rsp_q;
    logic [STAGES:0]         vld_pipe;
    rsp_t [STAGES:0]         rsp_pipe;

    assign vld_pipe = {vld_q, vld_i};
    assign rsp_pipe = {rsp_q, rsp_i};

    // Shift valid every cycle; capture payload only when a beat is present.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        rsp_q <= '0;
      end else begin
        for (int s = 0; s < STAGES; s++) begin
          vld_q[s] <= vld_pipe[s];
          if (vld_pipe[s]) rsp_q[s] <= rsp_pipe[s];
        end
      end
    end

    assign vld_o = vld_pipe[STAGES];
    assign rsp_o = rsp_pipe[STAGES];
  end

endmodule

// File: rtl/boot_rom_ctrl.sv
// Boot ROM slave on the req/gnt/r_valid bus. Writes and out-of-window
// addresses get an error response. Optional patch table enabled by the
// BOOT_ROM_PATCH_EN macro overrides selected ROM words.
module boot_rom_ctrl
  import boot_rom_pkg::*;
#(
  parameter int unsigned ROM_ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned READ_LAT       = 1,
  parameter int unsigned INIT_CYCLES    = 4,
  parameter int unsigned NUM_PATCH      = 4,
  localparam int unsigned BE_W = DATA_WIDTH / 8,
  localparam int unsigned OFS  = $clog2(BE_W),
  localparam int unsigned WAW  = ROM_ADDR_WIDTH - OFS,
  localparam int unsigned PIW  = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  init_ni,
  input  logic                  test_mode_i,
  input  logic                  req_i,
  input  logic [31:0]           add_i,
  input  logic                  wen_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
`ifdef BOOT_ROM_PATCH_EN
  input  logic                  patch_we_i,
  input  logic [PIW-1:0]        patch_idx_i,
  input  logic [WAW-1:0]        patch_addr_i,
  input  logic [DATA_WIDTH-1:0] patch_data_i,
  input  logic                  patch_lock_i,
`endif
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_opc_o
);

  localparam int unsigned LAT   = (READ_LAT < 1) ? 1 :
                                  (READ_LAT > MAX_READ_LAT) ? MAX_READ_LAT : READ_LAT;
  localparam int unsigned CNT_W = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt;
  logic              err;
  logic [WAW-1:0]    word;
  logic [MAX_DATA_W-1:0] rom_full;
  logic [DATA_WIDTH-1:0] rd_data;
  rsp_t              s1_d, s1_q, out_rsp;
  logic              s1_vld_q, out_vld;

  // Init countdown and run state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; grant is combinational on req_i only while running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      INIT: begin
        if (!init_ni) cnt_d = '0;
        else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      RUN: begin
        gnt = req_i;
        if (!init_ni) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign gnt_o    = gnt;
  assign err      = ~wen_i | (add_i[31:ROM_ADDR_WIDTH] != '0);
  assign word     = add_i[ROM_ADDR_WIDTH-1:OFS];
  assign rom_full = rom_word(32'(word));

`ifdef BOOT_ROM_PATCH_EN
  patch_entry_t [NUM_PATCH-1:0] patch_q;
  logic                         lock_q;

  // Patch table writes; lock is sticky and also blocks a write in its own cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      patch_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      lock_q <= lock_q | patch_lock_i;
      if (patch_we_i && !lock_q && !patch_lock_i && (32'(patch_idx_i) < NUM_PATCH))
        patch_q[patch_idx_i] <= '{valid: 1'b1,
                                  addr:  MAX_PADDR_W'(patch_addr_i),
                                  data:  MAX_DATA_W'(patch_data_i)};
    end
  end

  // Override lookup; scanning downward lets the lowest matching index win.
  always_comb begin
    rd_data = rom_full[DATA_WIDTH-1:0];
    for (int i = NUM_PATCH - 1; i >= 0; i--)
      if (patch_q[i].valid && (patch_q[i].addr[WAW-1:0] == word))
        rd_data = patch_q[i].data[DATA_WIDTH-1:0];
  end

  logic unused_ok;
  assign unused_ok = ^{be_i, wdata_i, test_mode_i, add_i[OFS-1:0], rom_full, out_rsp, patch_q};
`else
  assign rd_data = rom_full[DATA_WIDTH-1:0];

  logic unused_ok;
  assign unused_ok = ^{be_i, wdata_i, test_mode_i, add_i[OFS-1:0], rom_full, out_rsp};
`endif

  // Response beat for the granted access; errors never touch the ROM data.
  always_comb begin
    s1_d       = '0;
    s1_d.opc   = err;
    if (!err) s1_d.rdata = MAX_DATA_W'(rd_data);
  end

  // ROM output stage: first cycle of latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_vld_q <= gnt;
      if (gnt) s1_q <= s1_d;
    end
  end

  boot_rom_rsp_pipe #(.STAGES(LAT - 1)) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .vld_i  (s1_vld_q),
    .rsp_i  (s1_q),
    .vld_o  (out_vld),
    .rsp_o  (out_rsp)
  );

  assign r_valid_o = out_vld;
  assign r_rdata_o = out_rsp.rdata[DATA_WIDTH-1:0];
  assign r_opc_o   = out_rsp.opc;

endmodule

// File: tb/tb_boot_rom_ctrl.sv
// Directed bench for boot_rom_ctrl (READ_LAT=3, 32-bit, INIT_CYCLES=4).
// Patch-table steps are compiled in when BOOT_ROM_PATCH_EN is defined.
module tb_boot_rom_ctrl;

  localparam int AW = 13, DW = 32, LAT = 3, NP = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni, init_ni, test_mode_i, req_i, wen_i;
  logic [31:0]   add_i;
  logic [3:0]    be_i;
  logic [DW-1:0] wdata_i;
  logic          gnt_o, r_valid_o, r_opc_o;
  logic [DW-1:0] r_rdata_o;
`ifdef BOOT_ROM_PATCH_EN
  logic          patch_we_i, patch_lock_i;
  logic [1:0]    patch_idx_i;
  logic [10:0]   patch_addr_i;
  logic [DW-1:0] patch_data_i;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  boot_rom_ctrl #(
    .ROM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(LAT), .INIT_CYCLES(4), .NUM_PATCH(NP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .init_ni(init_ni), .test_mode_i(test_mode_i),
    .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .be_i(be_i), .wdata_i(wdata_i),
`ifdef BOOT_ROM_PATCH_EN
    .patch_we_i(patch_we_i), .patch_idx_i(patch_idx_i), .patch_addr_i(patch_addr_i),
    .patch_data_i(patch_data_i), .patch_lock_i(patch_lock_i),
`endif
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Single transaction: grant now, check the response LAT cycles later.
  task automatic rd(input logic [31:0] a, input logic w, input logic [31:0] exp_d,
                    input logic exp_o, input string tag);
    req_i = 1'b1; wen_i = w; add_i = a;
    #1 chk({tag, "_gnt"}, 64'(gnt_o), 64'd1);
    tick();
    req_i = 1'b0; wen_i = 1'b1;
`ifdef BOOT_ROM_PATCH_EN
    patch_we_i = 1'b0; patch_lock_i = 1'b0;
`endif
    tick();
    tick();
    chk({tag, "_vld"},  64'(r_valid_o), 64'd1);
    chk({tag, "_data"}, 64'(r_rdata_o), 64'(exp_d));
    chk({tag, "_opc"},  64'(r_opc_o),   64'(exp_o));
  endtask

  initial begin
    rst_ni = 1'b0; init_ni = 1'b1; test_mode_i = 1'b0;
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h0; be_i = 4'hF; wdata_i = '0;
`ifdef BOOT_ROM_PATCH_EN
    patch_we_i = 1'b0; patch_lock_i = 1'b0; patch_idx_i = '0; patch_addr_i = '0; patch_data_i = '0;
`endif
    #3;
    chk("rst_gnt",   64'(gnt_o),     64'd0);
    chk("rst_vld",   64'(r_valid_o), 64'd0);
    chk("rst_rdata", 64'(r_rdata_o), 64'd0);
    chk("rst_opc",   64'(r_opc_o),   64'd0);
    #13 rst_ni = 1'b1;

    // Init wait: four cycles without grant, grant on the fifth.
    #1 chk("init_gnt_c1", 64'(gnt_o), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("init_gnt_c%0d", i), 64'(gnt_o), 64'd0);
    end
    tick();
    chk("first_gnt", 64'(gnt_o), 64'd1);

    // Back-to-back reads 0x0, 0x4, 0x8.
    tick(); add_i = 32'h4; #1 chk("b2b_gnt1", 64'(gnt_o), 64'd1);
    chk("b2b_novld1", 64'(r_valid_o), 64'd0);
    tick(); add_i = 32'h8; #1 chk("b2b_gnt2", 64'(gnt_o), 64'd1);
    chk("b2b_novld2", 64'(r_valid_o), 64'd0);
    tick(); req_i = 1'b0; #1
    chk("b2b_vld0", 64'(r_valid_o), 64'd1);
    chk("b2b_d0",   64'(r_rdata_o), 64'hC0DE0000);
    chk("b2b_opc0", 64'(r_opc_o),   64'd0);
    tick(); chk("b2b_vld1", 64'(r_valid_o), 64'd1);
    chk("b2b_d1", 64'(r_rdata_o), 64'hC0DE0001);
    tick(); chk("b2b_d2", 64'(r_rdata_o), 64'hC0DE0002);
    tick(); chk("b2b_idle", 64'(r_valid_o), 64'd0);
    chk("b2b_hold", 64'(r_rdata_o), 64'hC0DE0002);

    // Error responses: write 0x10, read 0x2000, then read 0x10 (ROM intact).
    req_i = 1'b1; wen_i = 1'b0; add_i = 32'h10; #1 chk("err_gnt", 64'(gnt_o), 64'd1);
    tick(); wen_i = 1'b1; add_i = 32'h2000;
    tick(); add_i = 32'h10;
    tick(); req_i = 1'b0; #1
    chk("wr_vld",  64'(r_valid_o), 64'd1);
    chk("wr_opc",  64'(r_opc_o),   64'd1);
    chk("wr_data", 64'(r_rdata_o), 64'd0);
    tick(); chk("oor_opc", 64'(r_opc_o), 64'd1);
    chk("oor_data", 64'(r_rdata_o), 64'd0);
    tick(); chk("rom_ok_opc", 64'(r_opc_o), 64'd0);
    chk("rom_ok_data", 64'(r_rdata_o), 64'hC0DE0004);
    tick(); chk("err_idle", 64'(r_valid_o), 64'd0);

    // init_ni drop mid-stream: granted reads still return.
    req_i = 1'b1; add_i = 32'h0; #1 chk("ini_gntA", 64'(gnt_o), 64'd1);
    tick(); add_i = 32'h4; init_ni = 1'b0; #1 chk("ini_gntB", 64'(gnt_o), 64'd1);
    tick(); add_i = 32'h8; #1 chk("ini_gntC", 64'(gnt_o), 64'd0);
    tick(); chk("ini_vldA", 64'(r_valid_o), 64'd1);
    chk("ini_dA", 64'(r_rdata_o), 64'hC0DE0000);
    tick(); chk("ini_dB", 64'(r_rdata_o), 64'hC0DE0001);
    tick(); chk("ini_vld_end", 64'(r_valid_o), 64'd0);
    add_i = 32'hC; init_ni = 1'b1; #1 chk("reinit_gnt0", 64'(gnt_o), 64'd0);
    tick(); tick(); tick();
    chk("reinit_gnt3", 64'(gnt_o), 64'd0);
    tick();
    rd(32'hC, 1'b1, 32'hC0DE0003, 1'b0, "reinit_rd");
    rd(32'h9, 1'b1, 32'hC0DE0002, 1'b0, "unaligned");

`ifdef BOOT_ROM_PATCH_EN
    patch_we_i = 1'b1; patch_idx_i = 2'd3; patch_addr_i = 11'h5; patch_data_i = 32'h3333_3333;
    tick();
    patch_idx_i = 2'd1; patch_data_i = 32'h1111_1111;
    tick();
    patch_idx_i = 2'd0; patch_addr_i = 11'h2; patch_data_i = 32'hDEAD_BEEF;
    rd(32'h8,  1'b1, 32'hC0DE0002, 1'b0, "patch_same_cycle");
    rd(32'h8,  1'b1, 32'hDEADBEEF, 1'b0, "patch_hit");
    rd(32'h14, 1'b1, 32'h11111111, 1'b0, "patch_lowest");
    rd(32'h10, 1'b1, 32'hC0DE0004, 1'b0, "patch_miss");
    patch_lock_i = 1'b1; patch_we_i = 1'b1; patch_idx_i = 2'd0; patch_data_i = 32'h0BAD_0001;
    tick();
    patch_lock_i = 1'b0; patch_data_i = 32'h0BAD_0002;
    tick();
    patch_we_i = 1'b0;
    rd(32'h8, 1'b1, 32'hDEADBEEF, 1'b0, "patch_locked");
`endif

    // Async reset with a read in flight: response is discarded.
    req_i = 1'b1; add_i = 32'h4; #1 chk("ar_gnt", 64'(gnt_o), 64'd1);
    tick(); req_i = 1'b0; rst_ni = 1'b0; #1
    chk("ar_vld",   64'(r_valid_o), 64'd0);
    chk("ar_rdata", 64'(r_rdata_o), 64'd0);
    tick(); rst_ni = 1'b1;
    tick(); tick();
    chk("ar_no_rsp", 64'(r_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
